// File: rtl/tl_phase_sched.sv
// tl_phase_sched: two-direction traffic-light phase scheduler. It cycles
// G1 -> Y12 -> G2 -> Y21, falls back to flashing night mode when run is low,
// shortens a green for waiting pedestrians, and yields to emergency requests.
// Ports: clk / rst_n (async, active-low); tick_1s 1 s timebase pulse; run
//   selects cycling vs night; rg_time / y_time set the green / yellow lengths;
//   ped_req are per-crosswalk pulses; emg_req are per-direction levels;
//   phase, remain, ped_walk, ped_pending and preempt are all registered.
module tl_phase_sched #(
  parameter int CNT_WIDTH   = 11,
  parameter int SHORT_GREEN = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_1s,
  input  logic                 run,
  input  logic [CNT_WIDTH-1:0] rg_time,
  input  logic [CNT_WIDTH-1:0] y_time,
  input  logic [1:0]           ped_req,
  input  logic [1:0]           emg_req,
  output logic [2:0]           phase,
  output logic [CNT_WIDTH-1:0] remain,
  output logic [1:0]           ped_walk,
  output logic [1:0]           ped_pending,
  output logic                 preempt
);

  typedef enum logic [2:0] {
    NIGHT = 3'd0,
    G1    = 3'd1,
    Y12   = 3'd2,
    G2    = 3'd3,
    Y21   = 3'd4
  } phase_e;

  localparam logic [CNT_WIDTH-1:0] SHORT_VAL = CNT_WIDTH'(SHORT_GREEN);
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

  phase_e               state_q, state_d, seq_next;
  logic [CNT_WIDTH-1:0] remain_d;
  logic [CNT_WIDTH-1:0] load_val;
  logic [1:0]           pend_d, served_q, served_d, walk_d;
  logic                 preempt_d;
  logic                 load;    // a new phase is entered on this edge
  logic                 green;   // current phase is G1 or G2
  logic                 own;     // direction index served by the current green
  logic                 winner;  // emergency bit in force (bit 0 has priority)

  // Normal sequence successor; NIGHT always leaves to G1.
  always_comb begin
    case (state_q)
      G1:      seq_next = Y12;
      Y12:     seq_next = G2;
      G2:      seq_next = Y21;
      default: seq_next = G1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    remain_d  = remain;
    pend_d    = ped_pending;
    served_d  = served_q;
    preempt_d = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    green     = (state_q == G1) || (state_q == G2);
    own       = (state_q == G2);
    winner    = ~emg_req[0];

    if (!run) begin
      state_d  = NIGHT;
      remain_d = '0;
      pend_d   = '0;
      served_d = '0;
    end else if (state_q == NIGHT) begin
      // Pedestrian pulses arriving while still dark are dropped.
      state_d = G1;
      load    = 1'b1;
    end else begin
      pend_d = ped_pending | ped_req;
      if (green && (emg_req != 2'b00)) begin
        // Emergency for our own direction freezes the countdown; for the
        // crossing direction it cuts straight into yellow.
        preempt_d = 1'b1;
        if (winner != own) begin
          state_d = seq_next;
          load    = 1'b1;
        end
      end else if (green && pend_d[own] && (remain > SHORT_VAL)) begin
        // remain never grows inside a phase, so this fires at most once.
        remain_d = SHORT_VAL;
      end else if (tick_1s) begin
        if (remain > ONE) begin
          remain_d = remain - ONE;
        end else begin
          state_d = seq_next;
          load    = 1'b1;
        end
      end
    end

    if (load) begin
      load_val = ((state_d == G1) || (state_d == G2)) ? rg_time : y_time;
      remain_d = (load_val == '0) ? ONE : load_val;
      // Entering a green serves the crosswalk that crosses the other
      // direction; a request arriving on this same edge is served too.
      if (state_d == G1) begin
        served_d[1] = pend_d[1];
        pend_d[1]   = 1'b0;
      end
      if (state_d == G2) begin
        served_d[0] = pend_d[0];
        pend_d[0]   = 1'b0;
      end
    end

    walk_d = {(state_d == G1) && served_d[1], (state_d == G2) && served_d[0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= NIGHT;
      remain      <= '0;
      ped_pending <= '0;
      served_q    <= '0;
      ped_walk    <= '0;
      preempt     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain      <= remain_d;
      ped_pending <= pend_d;
      served_q    <= served_d;
      ped_walk    <= walk_d;
      preempt     <= preempt_d;
    end
  end

  assign phase = state_q;

endmodule

// File: doc/tl_phase_sched.md
TL_PHASE_SCHED -- requirements
Module: tl_phase_sched

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 11: width of all duration and countdown values.
REQ-002 SHALL have parameter SHORT_GREEN, default 3: green remainder, in ticks, after a pedestrian-shortening event.
REQ-003 SHALL have port clk, input, 1: system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port tick_1s, input, 1: single-cycle 1 s timebase pulse.
REQ-006 SHALL have port run, input, 1: 1 = normal cycling; 0 = night (flashing-yellow) mode.
REQ-007 SHALL have port rg_time, input, CNT_WIDTH: green phase duration, in ticks.
REQ-008 SHALL have port y_time, input, CNT_WIDTH: yellow phase duration, in ticks.
REQ-009 SHALL have port ped_req, input, 2: single-cycle pulse per crosswalk; bit0 crosses direction-1 traffic, bit1 crosses direction-2 traffic.
REQ-010 SHALL have port emg_req, input, 2: level emergency request; bit d demands green for direction d+1.
REQ-011 SHALL have port phase, output, 3: 0 NIGHT, 1 G1, 2 Y12, 3 G2, 4 Y21.
REQ-012 SHALL have port remain, output, CNT_WIDTH: ticks left in current phase.
REQ-013 SHALL have port ped_walk, output, 2: walk lamp; bit0 = (phase==G2), bit1 = (phase==G1), each gated by its served-request flag.
REQ-014 SHALL have port ped_pending, output, 2: latched, not-yet-served pedestrian requests.
REQ-015 SHALL have port preempt, output, 1: high while any emergency request is acting on the sequence.

Function
REQ-016 SHALL register phase, remain, ped_walk, ped_pending and preempt; no combinational path from inputs to outputs.
REQ-017 SHALL cycle G1 -> Y12 -> G2 -> Y21 -> G1 when run=1.
REQ-018 SHALL move from NIGHT to G1 on the first clk with run=1.
REQ-019 SHALL, on any clk with run=0, enter NIGHT within 1 cycle and clear remain, ped_pending, ped_walk and preempt.
REQ-020 SHALL load remain on phase entry: rg_time for G phases, y_time for Y phases; a value of 0 loads as 1.
REQ-021 SHALL sample rg_time and y_time only at load; mid-phase changes take effect at the next load.
REQ-022 SHALL, on tick_1s with remain>1, decrement remain by 1.
REQ-023 SHALL, on tick_1s with remain==1, advance the phase and load the new duration in the same cycle, so each phase lasts exactly its loaded tick count.
REQ-024 SHALL set ped_pending[i] on a ped_req[i] pulse while run=1; pulses in NIGHT are ignored.
REQ-025 SHALL clear ped_pending[0] on entry to G2 and ped_pending[1] on entry to G1, and latch a served flag that drives ped_walk for that whole green.
REQ-026 SHALL give set priority when a ped_req pulse coincides with its clearing entry: the request is served and pending ends at 0.
REQ-027 SHALL, when ped_pending[0] is set during G1 (or ped_pending[1] during G2) and remain>SHORT_GREEN, load remain with SHORT_GREEN on the next cycle, at most once per phase.
REQ-028 SHALL, while emg_req[0]=1 in G1, hold remain (ignore tick_1s) and assert preempt.
REQ-029 SHALL, on emg_req[0]=1 in G2, enter Y21 on the next cycle with y_time loaded and assert preempt.
REQ-030 SHALL apply REQ-028/029 symmetrically for emg_req[1] with G2/G1 and Y12.
REQ-031 SHALL leave Y phases unaffected by emergency and pedestrian requests.
REQ-032 SHALL give emg_req[0] priority when both emergency bits are high.
REQ-033 SHALL give emergency cutoff priority over pedestrian shortening when both occur in the same cycle.
REQ-034 SHALL let a tick_1s coinciding with a phase load not decrement the newly loaded value.

Reset
REQ-035 SHALL, while rst_n=0, force phase=NIGHT, remain=0, ped_pending=0, ped_walk=0, preempt=0 and clear shortening/served flags.
REQ-036 SHALL, on reset release with run=1, enter G1 on the first clk edge.
REQ-037 SHALL discard an in-progress phase when reset is asserted mid-operation; no state is retained.

Verification
REQ-038 SHALL be verified by: rg_time=8, y_time=6, run=1, no requests -> G1 for 8 ticks, Y12 for 6, G2 for 8, Y21 for 6, back to G1; remain 8..1 in G1.
REQ-039 SHALL be verified by: ped_req[0] pulse in G1 at remain=7, SHORT_GREEN=3 -> remain=3 next cycle; G2 entry clears ped_pending[0]; ped_walk[0]=1 for all of G2.
REQ-040 SHALL be verified by: emg_req[0]=1 in G2 at remain=5 -> Y21 next cycle with remain=6, preempt=1; G1 remain frozen at 8 while emg_req[0] stays high; normal countdown on release.
REQ-041 SHALL be verified by: both emg_req bits high in Y12 -> Y12 completes, then G2 cut to Y21 next cycle, G1 held.
REQ-042 SHALL be verified by: run dropped mid-G2 -> phase=NIGHT next cycle, remain=0, pending=0; run=1 -> G1 with current rg_time.
REQ-043 SHALL be verified by: rg_time=0 -> G1 lasts 1 tick; rst_n pulsed low mid-Y12 -> all outputs at reset values immediately.
